// File: rtl/cache_port_arbiter.sv
// Two-requester arbiter in front of the single CPU port of the write-back cache.
// Hits complete in the request cycle; misses lock the grant until the stall clears.
module cache_port_arbiter #(
    parameter int ARB_MODE   = 0,
    parameter int MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        cache_read_en,
    output logic        cache_write_en,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_write_din,
    input  logic [31:0] cache_read_dout,
    input  logic        cache_stall,
    output logic        busy,
    output logic        grant_d,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_d_q, last_d_d;
    logic [3:0]  consec_q, consec_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        busy_q, busy_d;

    logic        sel_d;
    logic        sel_valid;
    logic        tie_pick_d;
    logic        active;
    logic        ack;

    always_comb begin
        if (ARB_MODE == 0) begin
            tie_pick_d = ~last_d_q;
        end else begin
            tie_pick_d = (consec_q != 4'(MAX_CONSEC));
        end

        sel_valid = 1'b0;
        sel_d     = 1'b0;
        if (state_q == LOCK) begin
            sel_valid = 1'b1;
            sel_d     = owner_q;
        end else if (i_req && d_req) begin
            sel_valid = 1'b1;
            sel_d     = tie_pick_d;
        end else if (d_req) begin
            sel_valid = 1'b1;
            sel_d     = 1'b1;
        end else if (i_req) begin
            sel_valid = 1'b1;
            sel_d     = 1'b0;
        end

        active = sel_valid & ~rst;
        ack    = active & ~cache_stall;

        cache_read_en   = 1'b0;
        cache_write_en  = 1'b0;
        cache_addr      = 32'd0;
        cache_write_din = 32'd0;
        if (active) begin
            if (sel_d) begin
                cache_read_en   = ~d_we;
                cache_write_en  = d_we;
                cache_addr      = d_addr;
                cache_write_din = d_wdata;
            end else begin
                cache_read_en   = 1'b1;
                cache_addr      = i_addr;
            end
        end

        i_ack   = ack & ~sel_d;
        d_ack   = ack & sel_d;
        i_rdata = cache_read_dout;
        d_rdata = cache_read_dout;
        grant_d = sel_d;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d_d = last_d_q;
        consec_d = consec_q;

        if (state_q == IDLE) begin
            if (sel_valid && cache_stall) begin
                state_d = LOCK;
                owner_d = sel_d;
            end
        end else if (!cache_stall) begin
            state_d = IDLE;
        end

        // consec_q only matters while I is waiting, so any idle-I D ack clears it
        if (ack) begin
            last_d_d = sel_d;
            if (sel_d && i_req) begin
                consec_d = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;
            end else begin
                consec_d = 4'd0;
            end
        end

        stall_cycles_d = stall_cycles_q;
        if (cache_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end

        busy_d = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            last_d_q       <= 1'b0;
            consec_q       <= 4'd0;
            stall_cycles_q <= 32'd0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_d_q       <= last_d_d;
            consec_q       <= consec_d;
            stall_cycles_q <= stall_cycles_d;
            busy_q         <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: round-robin and D-priority instances
// share the same stimulus; expected acks are queued per instance.
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] cache_read_dout;
    logic        cache_stall;

    logic [31:0] i_rdata0, d_rdata0, cache_addr0, cache_write_din0, stall_cycles0;
    logic        i_ack0, d_ack0, cache_read_en0, cache_write_en0, busy0, grant_d0;
    logic [31:0] i_rdata1, d_rdata1, cache_addr1, cache_write_din1, stall_cycles1;
    logic        i_ack1, d_ack1, cache_read_en1, cache_write_en1, busy1, grant_d1;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } ack_t;

    ack_t q0[$];
    ack_t q1[$];
    int   checkCount = 0;
    int   errorCount = 0;

    always #5 clk = ~clk;

    cache_port_arbiter #(.ARB_MODE(0), .MAX_CONSEC(4)) dut0 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata0), .i_ack(i_ack0),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata0), .d_ack(d_ack0),
        .cache_read_en(cache_read_en0), .cache_write_en(cache_write_en0),
        .cache_addr(cache_addr0), .cache_write_din(cache_write_din0),
        .cache_read_dout(cache_read_dout), .cache_stall(cache_stall),
        .busy(busy0), .grant_d(grant_d0), .stall_cycles(stall_cycles0)
    );

    cache_port_arbiter #(.ARB_MODE(1), .MAX_CONSEC(2)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .cache_read_en(cache_read_en1), .cache_write_en(cache_write_en1),
        .cache_addr(cache_addr1), .cache_write_din(cache_write_din1),
        .cache_read_dout(cache_read_dout), .cache_stall(cache_stall),
        .busy(busy1), .grant_d(grant_d1), .stall_cycles(stall_cycles1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                                 input logic [31:0] dout, input logic st, input logic r);
        i_req           = ir;
        i_addr          = ia;
        d_req           = dr;
        d_we            = dw;
        d_addr          = da;
        d_wdata         = dwd;
        cache_read_dout = dout;
        cache_stall     = st;
        rst             = r;
    endtask

    task automatic pushExp(input int which, input logic is_d, input logic [31:0] data);
        ack_t e;
        e.is_d = is_d;
        e.data = data;
        if (which != 1) q0.push_back(e);
        if (which != 0) q1.push_back(e);
    endtask

    task automatic monitorDut(input int which, input logic ia, input logic da,
                              input logic [31:0] ir, input logic [31:0] dr);
        ack_t e;
        int   sz;
        if (ia && da) checkOutput($sformatf("dual_ack%0d", which), {31'd0, ia & da}, 32'd0);
        if (ia || da) begin
            sz = (which == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                checkOutput($sformatf("spurious_ack%0d", which), sz, 32'd1);
            end else begin
                e = (which == 0) ? q0.pop_front() : q1.pop_front();
                checkOutput($sformatf("ack_owner%0d", which), {31'd0, da}, {31'd0, e.is_d});
                checkOutput($sformatf("ack_data%0d", which), da ? dr : ir, e.data);
            end
        end
    endtask

    task automatic monitorAll();
        monitorDut(0, i_ack0, d_ack0, i_rdata0, d_rdata0);
        monitorDut(1, i_ack1, d_ack1, i_rdata1, d_rdata1);
    endtask

    task automatic checkQueues(input string tag);
        checkOutput({tag, "_left0"}, q0.size(), 32'd0);
        checkOutput({tag, "_left1"}, q1.size(), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // reset: requests present but everything gated
        applyStimulus(1, 32'h40, 1, 1, 32'h800, 32'hAA, 32'h0, 0, 1);
        @(negedge clk);
        checkOutput("rst_i_ack", {31'd0, i_ack0}, 32'd0);
        checkOutput("rst_d_ack", {31'd0, d_ack0}, 32'd0);
        checkOutput("rst_read_en", {31'd0, cache_read_en0}, 32'd0);
        checkOutput("rst_write_en", {31'd0, cache_write_en0}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy0}, 32'd0);
        checkOutput("rst_stall_cycles", stall_cycles0, 32'd0);
        advance();

        // idle
        for (int c = 0; c < 2; c++) begin
            applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h9999, 0, 0);
            @(negedge clk);
            checkOutput("idle_read_en", {31'd0, cache_read_en0}, 32'd0);
            checkOutput("idle_write_en", {31'd0, cache_write_en0}, 32'd0);
            checkOutput("idle_addr", cache_addr0, 32'd0);
            checkOutput("idle_stall_cycles", stall_cycles0, 32'd0);
            monitorAll();
            advance();
        end
        checkQueues("idle");

        // hit, I only
        applyStimulus(1, 32'h40, 0, 0, 32'h0, 32'h0, 32'h1234, 0, 0);
        pushExp(2, 1'b0, 32'h1234);
        @(negedge clk);
        checkOutput("hit_i_ack", {31'd0, i_ack0}, 32'd1);
        checkOutput("hit_read_en", {31'd0, cache_read_en0}, 32'd1);
        checkOutput("hit_addr", cache_addr0, 32'h40);
        checkOutput("hit_busy", {31'd0, busy0}, 32'd0);
        monitorAll();
        advance();
        checkQueues("hit");

        // miss lock: D store misses for 5 cycles, I arrives on cycle 2
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(c >= 2, 32'h80, c <= 6, 1, 32'h800, 32'hAA, 32'h5A5A_0000 + c, c <= 5, 0);
            if (c == 6) pushExp(2, 1'b1, 32'h5A5A_0006);
            if (c == 7) pushExp(2, 1'b0, 32'h5A5A_0007);
            @(negedge clk);
            if (c <= 6) begin
                checkOutput($sformatf("miss_write_en_c%0d", c), {31'd0, cache_write_en0}, 32'd1);
                checkOutput($sformatf("miss_addr_c%0d", c), cache_addr0, 32'h800);
                checkOutput($sformatf("miss_wdin_c%0d", c), cache_write_din0, 32'hAA);
            end
            checkOutput($sformatf("miss_busy_c%0d", c), {31'd0, busy0}, {31'd0, c >= 2 && c <= 6});
            checkOutput($sformatf("miss_i_ack_c%0d", c), {31'd0, i_ack0}, {31'd0, c == 7});
            monitorAll();
            advance();
        end
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("miss_stall_cycles0", stall_cycles0, 32'd5);
        checkOutput("miss_stall_cycles1", stall_cycles1, 32'd5);
        monitorAll();
        advance();
        checkQueues("miss");

        // tie with hits: RR alternates D,I,D,I; D-priority gives D,D,I,D
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, 32'h100, 1, 0, 32'h200, 32'h0, 32'hC0DE_0000 + c, 0, 0);
            pushExp(0, (c % 2) == 0, 32'hC0DE_0000 + c);
            pushExp(1, c != 2, 32'hC0DE_0000 + c);
            @(negedge clk);
            checkOutput($sformatf("rr_addr_c%0d", c), cache_addr0, ((c % 2) == 0) ? 32'h200 : 32'h100);
            monitorAll();
            advance();
        end
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        advance();
        checkQueues("rr");

        // reset in the middle of a locked miss
        for (int c = 0; c < 4; c++) begin
            applyStimulus(c < 3, 32'h0, c < 3, 0, 32'h300, 32'h0, 32'h7777, c < 3, c == 2);
            if (c == 0) i_req = 1'b0;
            @(negedge clk);
            if (c == 1) checkOutput("rlock_busy", {31'd0, busy0}, 32'd1);
            if (c == 2) begin
                checkOutput("rlock_rst_d_ack", {31'd0, d_ack0}, 32'd0);
                checkOutput("rlock_rst_read_en", {31'd0, cache_read_en0}, 32'd0);
            end
            if (c == 3) begin
                checkOutput("rlock_after_busy", {31'd0, busy0}, 32'd0);
                checkOutput("rlock_after_stall_cycles", stall_cycles0, 32'd0);
            end
            monitorAll();
            advance();
        end
        checkQueues("rlock");

        // starvation guard after reset: last_d and consec_d back to 0
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1, 32'h104, 1, 1, 32'h204, 32'h55, 32'hBEEF_0000 + c, 0, 0);
            pushExp(0, (c % 2) == 0, 32'hBEEF_0000 + c);
            pushExp(1, (c % 3) != 2, 32'hBEEF_0000 + c);
            @(negedge clk);
            monitorAll();
            advance();
        end
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        advance();
        checkQueues("starve");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
